// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and flag definitions for the execute-stage ALU
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MOV = 3'b100,
    OP_MOD = 3'b101
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mod_unit.sv
// rtl/alu_mod_unit.sv - combinational unsigned remainder, divide-by-zero returns the dividend
module alu_mod_unit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] rem
);

  logic [N:0] part;

  // Restoring remainder: one extra bit so the shifted partial never wraps before the compare.
  always_comb begin
    part = '0;
    for (int i = N - 1; i >= 0; i--) begin
      part = {part[N-1:0], a[i]};
      if (part >= {1'b0, b}) begin
        part = part - {1'b0, b};
      end
    end
    rem = (b == '0) ? a : part[N-1:0];
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered N-bit ALU with NZCV flags for the execute stage
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [2:0]   opcode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   ALUFlags
);

  alu_op_e      op;
  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] rem;
  logic [N-1:0] res_d;
  logic [3:0]   flags_d;
  logic         c_d;
  logic         v_d;

  assign op   = alu_op_e'(opcode_i);
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  alu_mod_unit #(.N(N)) u_mod (
    .a   (a_i),
    .b   (b_i),
    .rem (rem)
  );

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = sum[N-1:0];
        c_d   = sum[N];
        v_d   = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        res_d = diff[N-1:0];
        // Carry is NOT borrow: the extended subtraction goes negative exactly when a < b.
        c_d   = ~diff[N];
        v_d   = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
      end
      OP_AND:  res_d = a_i & b_i;
      OP_OR:   res_d = a_i | b_i;
      OP_MOV:  res_d = b_i;
      OP_MOD:  res_d = rem;
      default: res_d = '0;
    endcase
  end

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = res_d[N-1];
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      ALUFlags <= '0;
    end else begin
      result_o <= res_d;
      ALUFlags <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - vector table plus scoreboard checks for the registered ALU
module tb_alu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [2:0]  opcode_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic [3:0]  ALUFlags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          due;
    int          tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  alu #(.N(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .opcode_i (opcode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .ALUFlags (ALUFlags)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, sr;
    logic [32:0] wide;
    logic c, v;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[31:0];
        c     = wide[32];
        sr    = longint'($signed(e.res));
        v     = (sa + sb_) != sr;
      end
      3'd1: begin
        e.res = a - b;
        c     = (a >= b);
        sr    = longint'($signed(e.res));
        v     = (sa - sb_) != sr;
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = b;
      3'd5: e.res = (b == 0) ? a : (a % b);
      default: e.res = 32'd0;
    endcase
    e.flags = {e.res[31], (e.res == 32'd0), c, v};
    e.due = 0;
    e.tag = 0;
    return e;
  endfunction

  task automatic drive(input int tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic [3:0] flags);
    exp_t e;
    opcode_i = op;
    a_i      = a;
    b_i      = b;
    e.res    = res;
    e.flags  = flags;
    e.due    = cyc + 1;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("result", e.tag, result_o, e.res);
      chk("flags", e.tag, {28'd0, ALUFlags}, {28'd0, e.flags});
    end
  end

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flags);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flags = flags;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    add_vec(3'd0, 32'd1, 32'd10, 32'd11, 4'b0000);
    add_vec(3'd1, 32'd10, 32'd10, 32'd0, 4'b0110);
    add_vec(3'd1, 32'd1, 32'd10, 32'hFFFFFFF7, 4'b1000);
    add_vec(3'd5, 32'd10, 32'd5, 32'd0, 4'b0100);
    add_vec(3'd5, 32'd10, 32'd3, 32'd1, 4'b0000);
    add_vec(3'd5, 32'd7, 32'd0, 32'd7, 4'b0000);
    add_vec(3'd2, 32'd10, 32'd10, 32'd10, 4'b0000);
    add_vec(3'd3, 32'd11, 32'd10, 32'd11, 4'b0000);
    add_vec(3'd4, 32'd11, 32'd11, 32'd11, 4'b0000);
    add_vec(3'd4, 32'd5, 32'd9, 32'd9, 4'b0000);
    add_vec(3'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001);
    add_vec(3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0110);
    add_vec(3'd6, 32'd5, 32'd3, 32'd0, 4'b0100);
    add_vec(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'b0100);
    add_vec(3'd5, 32'h80000000, 32'd7, 32'd2, 4'b0000);
    add_vec(3'd5, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 4'b1000);
    add_vec(3'd5, 32'd3, 32'd10, 32'd3, 4'b0000);
    add_vec(3'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
    add_vec(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000);

    rst_ni   = 1'b0;
    opcode_i = 3'd0;
    a_i      = 32'd123;
    b_i      = 32'd456;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_result", 0, result_o, 32'd0);
    chk("rst_flags", 0, {28'd0, ALUFlags}, 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
      @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
    chk("drain_table", 0, sb.size(), 32'd0);

    opcode_i = 3'd0;
    a_i      = 32'd5;
    b_i      = 32'd6;
    @(posedge clk_i);
    #2;
    chk("pre_async_result", 0, result_o, 32'd11);
    rst_ni = 1'b0;
    #1;
    chk("async_result", 0, result_o, 32'd0);
    chk("async_flags", 0, {28'd0, ALUFlags}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      e = model(rop, ra, rb);
      drive(1000 + i, rop, ra, rb, e.res, e.flags);
      @(negedge clk_i);
    end
    repeat (2) @(negedge clk_i);
    chk("drain_random", 0, sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered N-bit integer ALU for the RSA pipeline CPU execute stage.
- Performs ADD, SUB, AND, OR, MOV and MOD, selected by a 3-bit opcode.
- Drives a result and four NZCV condition flags consumed by the condition/flag logic.
- Outputs are registered: one cycle of latency from operands to result.

Parameters:
- N, 32, operand and result width in bits; legal for N >= 2.

Ports:
- clk_i  input  1  system clock, rising-edge active
- rst_ni  input  1  asynchronous active-low reset
- opcode_i  input  3  operation select
- a_i  input  N  operand A, unsigned for MOD
- b_i  input  N  operand B, unsigned for MOD
- result_o  output  N  registered operation result
- ALUFlags  output  4  registered flags {N,Z,C,V}, bit3=N, bit2=Z, bit1=C, bit0=V

Behaviour:
- Reset: while rst_ni=0 (asserted asynchronously), result_o=0 and ALUFlags=4'b0000. The first capture occurs on the first rising clk_i after rst_ni deasserts.
- Latency: inputs are sampled on every rising clk_i. result_o and ALUFlags reflect the sampled opcode/operands on the next rising edge. There is no enable or handshake; new operands are accepted every cycle.
- Opcode map:
  - 000 ADD: a + b (mod 2^N)
  - 001 SUB: a - b (mod 2^N)
  - 010 AND: a & b
  - 011 OR: a | b
  - 100 MOV: b
  - 101 MOD: a % b, unsigned
  - 110, 111 reserved: result 0
- Flag N = result[N-1] for every opcode.
- Flag Z = (result == 0) for every opcode. A reserved opcode therefore gives Z=1.
- Flag C:
  - ADD: carry out of bit N-1, from an N+1-bit sum.
  - SUB: NOT borrow, i.e. C=1 when a >= b unsigned (ARM convention).
  - All other ops: C=0.
- Flag V:
  - ADD: 1 when a and b have the same sign and the result sign differs.
  - SUB: 1 when a and b have different signs and the result sign differs from a.
  - All other ops: V=0.
- MOD with b=0: result = a, flags from that result with C=0, V=0. No X or trap.
- MOD is computed combinationally within the cycle using a full-width unsigned remainder. A synthesizable restoring-remainder array is acceptable. No multi-cycle stall.
- Reset mid-operation: the in-flight result is discarded and outputs go to 0 immediately.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [2:0] alu_op_e: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_MOV=100, OP_MOD=101.
  - localparams for flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_mod_unit: a parameterised N-bit combinational unsigned remainder with a divide-by-zero passthrough (returns a).
- Everything else stays in alu: the op mux, flag generation and output registers.

Test Plan:
- Reset: hold rst_ni=0 with nonzero inputs -> result_o=0, ALUFlags=0000. Release, apply ADD a=1 b=10 -> next edge result_o=11, flags 0000.
- SUB: a=10 b=10 -> result 0, N=0 Z=1 C=1 V=0.
- SUB: a=1 b=10 -> result 0xFFFFFFF7, N=1 C=0.
- MOD: a=10 b=5 -> result 0, Z=1.
- MOD: a=10 b=3 -> result 1.
- MOD: a=7 b=0 -> result 7.
- AND: a=10 b=10 -> result 10. OR: a=11 b=10 -> result 11. MOV: a=11 b=11 -> result 11. MOV: a=5 b=9 -> result 9. C=V=0 throughout.
- ADD overflow and carry:
  - a=0x7FFFFFFF b=1 -> 0x80000000, N=1 V=1 C=0.
  - a=0xFFFFFFFF b=1 -> 0, Z=1 C=1 V=0.
- Async reset mid-stream: assert rst_ni between clock edges -> outputs clear without waiting for clk_i.
- Back-to-back: a new opcode every cycle -> each result appears exactly one cycle after its inputs.
